// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and Gray decode helper for the event scheduler
package gray_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } sched_state_e;

   localparam int GRAY_MAX_W = 32;

   // Bits at and above w are ignored, so callers size the result to their own width.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                      input int w);
      logic [GRAY_MAX_W-1:0] b;
      logic                  acc;
      b   = '0;
      acc = 1'b0;
      for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
         if (i < w) begin
            acc  = acc ^ g[i];
            b[i] = acc;
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant starting the search at rr_ptr
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic            en_i,
   input  logic [PW-1:0]   rr_ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [PW-1:0]   idx_o
);

   logic found;
   int   k;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      k       = 0;
      for (int j = 0; j < NREQ; j++) begin
         k = (int'(rr_ptr_i) + j) % NREQ;
         if (en_i && !found && req_i[k]) begin
            grant_o[k] = 1'b1;
            idx_o      = PW'(k);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gray_event_sched.sv
// rtl/gray_event_sched.sv - Gray pointer advances to round-robin event tokens with hazard detection
module gray_event_sched
   import gray_pkg::*;
#(
   parameter int WID            = 4,
   parameter int NREQ           = 4,
   parameter int HCNT_W         = 8,
   parameter bit HALT_ON_HAZARD = 1'b1
) (
   input  logic              clk2,
   input  logic              resetn,
   input  logic [WID-1:0]    din,
   input  logic              en,
   input  logic              clr,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   grant,
   output logic [WID-1:0]    pending,
   output logic              hazard,
   output logic [HCNT_W-1:0] hazard_cnt,
   output logic              overflow,
   output logic              fault
);

   localparam int PW = $clog2(NREQ);

   sched_state_e      state_q;
   logic [WID-1:0]    binbuf_q;
   logic [WID-1:0]    pending_q, pending_d;
   logic [PW-1:0]     rr_ptr_q;
   logic              hazard_q;
   logic [HCNT_W-1:0] hazard_cnt_q;
   logic              overflow_q, overflow_d;

   logic [WID-1:0]    dinbin;
   logic [WID-1:0]    delta;
   logic              inc;
   logic              haz;
   logic              take;
   logic              arb_en;
   logic [PW-1:0]     grant_idx;

   assign dinbin = WID'(gray2bin(GRAY_MAX_W'(din), WID));
   assign delta  = dinbin - binbuf_q;
   assign inc    = en && (delta == WID'(1));
   // Any jump of two or more steps means the synchronizers caught bits mid-transition.
   assign haz    = en && (delta > WID'(1));
   assign arb_en = (state_q == RUN) && (pending_q != '0);
   assign take   = |grant;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req_i    (req),
      .en_i     (arb_en),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (grant),
      .idx_o    (grant_idx)
   );

   always_comb begin
      pending_d  = pending_q;
      overflow_d = overflow_q;
      if (state_q == FAULT && clr && !haz) begin
         pending_d = '0;
      end else if (inc && !take) begin
         if (pending_q == '1) begin
            overflow_d = 1'b1;
         end else begin
            pending_d = pending_q + WID'(1);
         end
      end else if (take && !inc) begin
         pending_d = pending_q - WID'(1);
      end
   end

   always_ff @(posedge clk2) begin
      if (!resetn) begin
         state_q      <= RUN;
         binbuf_q     <= '0;
         pending_q    <= '0;
         rr_ptr_q     <= '0;
         hazard_q     <= 1'b0;
         hazard_cnt_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         binbuf_q   <= dinbin;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         hazard_q   <= haz;
         if (haz && hazard_cnt_q != '1) begin
            hazard_cnt_q <= hazard_cnt_q + HCNT_W'(1);
         end
         if (take) begin
            rr_ptr_q <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
         end
         case (state_q)
            RUN: begin
               if (haz && HALT_ON_HAZARD) begin
                  state_q <= FAULT;
               end
            end
            FAULT: begin
               if (clr && !haz) begin
                  state_q <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign pending    = pending_q;
   assign hazard     = hazard_q;
   assign hazard_cnt = hazard_cnt_q;
   assign overflow   = overflow_q;
   assign fault      = (state_q == FAULT);

endmodule

// File: tb/tb_gray_event_sched.sv
// tb/tb_gray_event_sched.sv - scoreboard bench for gray_event_sched
module tb_gray_event_sched;

   logic       clk2;
   logic       resetn;
   logic [3:0] din;
   logic       en;
   logic       clr;
   logic [3:0] req;
   logic [3:0] grant;
   logic [3:0] pending;
   logic       hazard;
   logic [7:0] hazard_cnt;
   logic       overflow;
   logic       fault;

   logic [3:0] bptr;
   int         exp_q[$];
   int         total = 0;
   int         bad   = 0;

   gray_event_sched #(
      .WID            (4),
      .NREQ           (4),
      .HCNT_W         (8),
      .HALT_ON_HAZARD (1'b1)
   ) dut (
      .clk2       (clk2),
      .resetn     (resetn),
      .din        (din),
      .en         (en),
      .clr        (clr),
      .req        (req),
      .grant      (grant),
      .pending    (pending),
      .hazard     (hazard),
      .hazard_cnt (hazard_cnt),
      .overflow   (overflow),
      .fault      (fault)
   );

   initial clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   // Every observed grant must match the next expected index in the scoreboard.
   always @(negedge clk2) begin
      if (grant !== 4'b0000) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_grant: got %b, required none", grant);
         end else begin
            int e;
            logic [3:0] exp_g;
            e     = exp_q.pop_front();
            exp_g = 4'b0001 << e;
            if (grant !== exp_g) begin
               bad++;
               $display("FAIL grant_order: got %b, required %b", grant, exp_g);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk2);
      #1;
   endtask

   task automatic set_ptr(input logic [3:0] b);
      bptr = b;
      din  = b ^ (b >> 1);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      en     = 1'b1;
      clr    = 1'b0;
      req    = 4'b0000;
      set_ptr(4'd0);
      exp_q.delete();
      step(2);
      resetn = 1'b1;
   endtask

   task automatic check_drained(input string name);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: %0d grants outstanding, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      en     = 1'b1;
      clr    = 1'b0;
      req    = 4'b0000;
      set_ptr(4'd0);
      step(2);
      @(negedge clk2);
      total++;
      if ({grant, pending, hazard, hazard_cnt, overflow, fault} !== 19'd0) begin
         bad++;
         $display("FAIL reset_outputs: got grant=%b pending=%0d hazard=%b cnt=%0d ovf=%b fault=%b, required all 0",
                  grant, pending, hazard, hazard_cnt, overflow, fault);
      end
      resetn = 1'b1;
      step(1);
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      for (int i = 1; i <= 3; i++) begin
         set_ptr(4'(i));
         exp_q.push_back(0);
         @(negedge clk2);
         total++;
         if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL single_early_grant: got %b, required 0000", grant);
         end
         @(negedge clk2);
         total++;
         if (pending !== 4'd1 || grant !== 4'b0001) begin
            bad++;
            $display("FAIL single_latency: got pending=%0d grant=%b, required 1 0001", pending, grant);
         end
         step(2);
      end
      total++;
      if (pending !== 4'd0) begin
         bad++;
         $display("FAIL single_pending: got %0d, required 0", pending);
      end
      check_drained("single");
      req = 4'b0000;
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_ptr(bptr + 4'd1);
         step(1);
      end
      step(1);
      total++;
      if (pending !== 4'd6) begin
         bad++;
         $display("FAIL rr_build: got pending=%0d, required 6", pending);
      end
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(0);
         exp_q.push_back(1);
         exp_q.push_back(3);
      end
      req = 4'b1011;
      step(8);
      total++;
      if (pending !== 4'd0) begin
         bad++;
         $display("FAIL rr_pending: got %0d, required 0", pending);
      end
      check_drained("rr");
      req = 4'b0000;
   endtask

   task automatic test_hazard();
      do_reset();
      req = 4'b1111;
      set_ptr(4'd2);
      @(negedge clk2);
      @(negedge clk2);
      total++;
      if (hazard !== 1'b1 || hazard_cnt !== 8'd1 || fault !== 1'b1) begin
         bad++;
         $display("FAIL hazard_pulse: got hazard=%b cnt=%0d fault=%b, required 1 1 1", hazard, hazard_cnt, fault);
      end
      @(negedge clk2);
      total++;
      if (hazard !== 1'b0) begin
         bad++;
         $display("FAIL hazard_width: got %b, required 0", hazard);
      end
      step(1);
      set_ptr(4'd3);
      step(1);
      @(negedge clk2);
      total++;
      if (pending !== 4'd1 || fault !== 1'b1) begin
         bad++;
         $display("FAIL fault_track: got pending=%0d fault=%b, required 1 1", pending, fault);
      end
      step(1);
      set_ptr(4'd5);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      @(negedge clk2);
      total++;
      if (fault !== 1'b1 || hazard !== 1'b1 || hazard_cnt !== 8'd2 || pending !== 4'd1) begin
         bad++;
         $display("FAIL clr_vs_hazard: got fault=%b hazard=%b cnt=%0d pending=%0d, required 1 1 2 1",
                  fault, hazard, hazard_cnt, pending);
      end
      step(1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      @(negedge clk2);
      total++;
      if (fault !== 1'b0 || pending !== 4'd0) begin
         bad++;
         $display("FAIL clr_recover: got fault=%b pending=%0d, required 0 0", fault, pending);
      end
      step(2);
      check_drained("hazard");
      req = 4'b0000;
   endtask

   task automatic test_wrap_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         set_ptr(bptr + 4'd1);
         step(1);
      end
      step(1);
      total++;
      if (pending !== 4'd15 || overflow !== 1'b1 || hazard_cnt !== 8'd0) begin
         bad++;
         $display("FAIL wrap_overflow: got pending=%0d ovf=%b cnt=%0d, required 15 1 0", pending, overflow, hazard_cnt);
      end
   endtask

   task automatic test_flush();
      do_reset();
      en = 1'b0;
      set_ptr(4'd9);
      step(2);
      total++;
      if (hazard_cnt !== 8'd0 || pending !== 4'd0 || hazard !== 1'b0) begin
         bad++;
         $display("FAIL flush_track: got cnt=%0d pending=%0d hazard=%b, required 0 0 0", hazard_cnt, pending, hazard);
      end
      en = 1'b1;
      step(1);
      set_ptr(4'd10);
      step(2);
      total++;
      if (pending !== 4'd1 || hazard_cnt !== 8'd0) begin
         bad++;
         $display("FAIL flush_resume: got pending=%0d cnt=%0d, required 1 0", pending, hazard_cnt);
      end
      resetn = 1'b0;
      step(1);
      req = 4'b0001;
      @(negedge clk2);
      total++;
      if (grant !== 4'b0000 || pending !== 4'd0) begin
         bad++;
         $display("FAIL mid_reset: got grant=%b pending=%0d, required 0000 0", grant, pending);
      end
      resetn = 1'b1;
      req    = 4'b0000;
      set_ptr(4'd0);
      step(2);
      check_drained("flush");
   endtask

   initial begin
      resetn = 1'b0;
      en     = 1'b1;
      clr    = 1'b0;
      req    = 4'b0000;
      bptr   = 4'd0;
      din    = 4'd0;
      test_reset();
      test_single();
      test_round_robin();
      test_hazard();
      test_wrap_overflow();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gray_event_sched.md
# gray_event_sched

Clock-domain-2 consumer of a Gray-coded event pointer sent from the clk1 domain and already passed through per-bit 3-flop synchronizers. Converts each unit pointer advance into one event token, buffers tokens in a pending counter, and hands them out one per cycle to NREQ requesters by round-robin. Multi-step pointer jumps (sync hazards) are detected, counted, and optionally halt dispatch until software clears the fault.

## Interface
- WID, 4, pointer width in bits (Gray and binary)
- NREQ, 4, number of requesters (≥2)
- HCNT_W, 8, hazard counter width
- HALT_ON_HAZARD, 1, 1 = enter FAULT on hazard; 0 = count only
- clk2  in  1  receive-domain clock
- resetn  in  1  reset, synchronous, active-low
- din  in  WID  synchronized Gray pointer
- en  in  1  1 = accept advances; 0 = flush/track mode
- clr  in  1  single-cycle fault clear
- req  in  NREQ  token requests, level
- grant  out  NREQ  one-hot token grant, at most one bit set
- pending  out  WID  buffered token count
- hazard  out  1  registered one-cycle hazard pulse
- hazard_cnt  out  HCNT_W  saturating hazard count
- overflow  out  1  sticky, token lost to full pending counter
- fault  out  1  1 while in FAULT

## Operation
- dinbin = Gray-to-binary(din): dinbin[WID-1]=din[WID-1], dinbin[i]=XOR of din[WID-1:i].
- binbuf: last accepted binary pointer; delta = (dinbin − binbuf) mod 2^WID.
- en=0: binbuf <= dinbin every cycle; no increments, no hazard checks.
- en=1, delta=0: nothing. delta=1: inc=1, binbuf <= dinbin. delta≥2: hazard, binbuf <= dinbin, tokens discarded (inc=0).
- pending_next = pending + inc − take, take = |grant. Inc at pending=2^WID−1 with no take: pending holds, overflow <= 1 (sticky until reset).
- grant: combinational from registered state; nonzero only when state=RUN, pending≠0, |req. Picks first set req at index ≥ rr_ptr, wrapping. On grant at index k, rr_ptr <= (k+1) mod NREQ.
- FSM states RUN, FAULT. RUN→FAULT on hazard when HALT_ON_HAZARD=1. FAULT: grants 0, advances still tracked and counted into pending. FAULT→RUN on clr: pending <= 0 same edge. clr in RUN: no effect.
- Hazard in FAULT: still pulses hazard and counts.
- hazard_cnt increments per hazard, saturates at all-ones; cleared only by reset.
- Reset: binbuf 0, pending 0, rr_ptr 0, state RUN, hazard 0, hazard_cnt 0, overflow 0; hence grant 0, fault 0.

## Timing
- din sampled in cycle N → pending updated at end of N → earliest grant in N+1.
- hazard pulses in cycle N+1 for a jump seen in N; fault asserts in N+1.
- Simultaneous inc and take: pending unchanged. Take with pending=1 and no inc: pending 0, no grant next cycle.
- Pointer wrap 2^WID−1→0 is delta=1, a valid advance.
- clr and hazard same cycle: hazard wins, stays FAULT.
- resetn low mid-operation: all state to reset values at that edge; grant 0 the following cycle.

## Structure
- Package gray_pkg: sched_state_e {RUN, FAULT}; function gray2bin parameterized via WID.
- Sub-module rr_arbiter (NREQ): inputs req, en, rr_ptr; output one-hot grant and granted index.
- Synchronizers stay outside this block.

## Test plan
- Reset: din=0, resetn low 2 cycles → all outputs 0, fault 0.
- Single advances: din 0→1→3→2 (Gray) one per 4 cycles, req=4'b0001 → grant[0] once per advance, one cycle after each step, pending returns to 0.
- Round-robin: pending built to 6 with req=0, then req=4'b1011 → grants 0,1,3,0,1,3, pending counts down to 0.
- Hazard: din jumps 0→3 (binary 0→2) with en=1 → hazard pulse next cycle, hazard_cnt=1, fault=1, no grants; clr → RUN, pending=0.
- Wrap and overflow: WID=4, 16 advances with req=0 including 15→0 step → pending=15, overflow=1, hazard_cnt=0.
- Flush: en=0 while din jumps 0→binary 9 → no hazard, pending unchanged; en=1 then one advance → pending+1.
